multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the 16-bit CPU.
- Latches the fetched instruction and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives every datapath strobe, and drives the ALUOp, OPCODE and Funct fields consumed by the ALU control decoder (the producing end of that interface).
- Sits between instruction/data memory and the register file/ALU datapath.

Parameters:
- MEM_TIMEOUT, 15, max cycles MemReq may stay high without MemReady before entering ERROR.
- TO_W, 4, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- InstrIn  input  16  memory read data, captured as the instruction in FETCH.
- MemReady  input  1  memory completion for the current MemReq.
- MemReq  output  1  memory access request.
- MemRead  output  1  read access.
- MemWrite  output  1  write access.
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- IRWrite  output  1  instruction-register load strobe to the datapath.
- PCWrite  output  1  unconditional PC update.
- PCWriteCond  output  1  PC update gated by the datapath with !Zero (BNE).
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = constant 1, 10 = sign-extended immediate.
- ALUOp  output  2  to ALU control: 00 = add, 01 = branch compare, 10 = R-type by Funct, 11 = I-type by OPCODE.
- OPCODE  output  3  latched Instr[15:13].
- Funct  output  4  latched Instr[3:0].
- RegWrite  output  1  register file write.
- RegDst  output  1  1 = rd, 0 = rt.
- MemToReg  output  1  1 = memory data, 0 = ALUOut.
- Illegal  output  1  one-cycle pulse on an unsupported R-type Funct.
- Error  output  1  sticky memory-timeout flag.

Behaviour:
- Opcode map:
  - 000 R-type; legal Funct = 0000 ADD, 0001 SUB, 0010 MOD, 1101 XOR.
  - 001 ANDI, 010 ORI, 100 SLTI.
  - 011 LW, 101 SW, 110 BNE, 111 J.
- Outputs are Moore outputs decoded from the state register. Exception: OPCODE and Funct are registers loaded in FETCH on MemReady.
- Reset (Reset = 0, any time, mid-access included):
  - state = RST; all outputs 0; OPCODE = 0, Funct = 0; wait counter = 0; Error = 0.
  - An outstanding MemReq is dropped immediately.
- RST -> FETCH unconditionally on the next edge.
- FETCH:
  - Drives MemReq = 1, MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - Holds until MemReady = 1. On that edge: IRWrite = 1 and PCWrite = 1 are asserted for that cycle, OPCODE/Funct are latched, and the FSM goes to DECODE.
  - IRWrite and PCWrite are qualified by MemReady.
- DECODE: ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target precompute). Next state by OPCODE:
  - 000 -> EXEC_R
  - 001/010/100 -> EXEC_I
  - 011/101 -> MEM_ADDR
  - 110 -> BRANCH
  - 111 -> JUMP
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10.
  - Legal Funct -> WB_R.
  - Illegal Funct -> FETCH with Illegal = 1 for this cycle; no writeback.
- WB_R: RegWrite = 1, RegDst = 1, MemToReg = 0 -> FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11 -> WB_I.
- WB_I: RegWrite = 1, RegDst = 0, MemToReg = 0 -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 -> MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: MemReq = 1, MemRead = 1, IorD = 1; waits for MemReady -> MEM_WB.
- MEM_WB: RegWrite = 1, RegDst = 0, MemToReg = 1 -> FETCH.
- MEM_WRITE: MemReq = 1, MemWrite = 1, IorD = 1; waits for MemReady -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01 -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10 -> FETCH.
- Wait counter:
  - Clears on entry to any MemReq state and whenever MemReady = 1.
  - Increments each cycle MemReq = 1 and MemReady = 0.
  - When it reaches MEM_TIMEOUT with MemReady still 0 -> ERROR.
  - MemReady = 1 on the same cycle the count hits MEM_TIMEOUT counts as success; the FSM does not enter ERROR.
- ERROR: all strobes 0, Error = 1, stays until Reset.
- MemReady while MemReq = 0 is ignored.
- Cycles per instruction with MemReady tied high: R/I/SW = 4, LW = 5, BNE/J = 3.

Test Plan:
- Reset low mid-FETCH with MemReq = 1 -> MemReq = 0 and all outputs 0 immediately. After release: one RST cycle, then FETCH with MemReq = 1, MemRead = 1.
- ADD, InstrIn = 0x1230 (OPCODE 000, Funct 0000), MemReady = 1:
  - Cycle 3 (EXEC_R): ALUOp = 10, Funct = 0000.
  - Cycle 4 (WB_R): RegWrite = 1, RegDst = 1.
  - Cycle 5: back in FETCH.
- ORI, InstrIn = 0x4005 -> EXEC_I with ALUOp = 11, OPCODE = 010, then WB_I with RegWrite = 1, RegDst = 0. Repeat with InstrIn = 0xC005 -> BNE: 3-cycle sequence with PCWriteCond = 1, ALUOp = 01, no RegWrite.
- LW, InstrIn = 0x6004, MemReady low 3 cycles in MEM_READ -> MEM_READ held exactly 4 cycles. Then MEM_WB with MemToReg = 1 and RegWrite = 1; total 8 cycles.
- Illegal R-type, Funct = 0111 -> Illegal pulses 1 cycle in EXEC_R, RegWrite never asserts, next state FETCH.
- MemReady held 0 in FETCH -> ERROR reached after MEM_TIMEOUT = 15 wait cycles. Error stays 1 and MemReq stays 0 until Reset.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM: latches OPCODE/Funct in FETCH and sequences the datapath strobes.
// Strobes are Moore outputs; IRWrite/PCWrite in FETCH are gated by MemReady. A memory wait longer than MEM_TIMEOUT ends in a sticky ERROR.
module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] InstrIn,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [2:0]  OPCODE,
  output logic [3:0]  Funct,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        Illegal,
  output logic        Error
);

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ERROR
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            mem_state;
  logic            timed_out;
  logic            funct_ok;
  logic            unused_instr;

  // Only the opcode and funct fields matter to control; the rest belongs to the datapath.
  assign unused_instr = ^InstrIn[12:4];

  assign mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign timed_out = (wait_cnt == TO_MAX);

  always_comb begin
    funct_ok = 1'b0;
    case (Funct)
      4'b0000, 4'b0001, 4'b0010, 4'b1101: funct_ok = 1'b1;
      default:                            funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter sits at zero outside memory states, so every memory access starts its wait from zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= '0;
      OPCODE   <= '0;
      Funct    <= '0;
    end else begin
      if (mem_state && !MemReady) begin
        if (!timed_out) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      if ((state == FETCH) && MemReady) begin
        OPCODE <= InstrIn[15:13];
        Funct  <= InstrIn[3:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    MemReq      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    Illegal     = 1'b0;
    Error       = 1'b0;
    case (state)
      RST: state_nxt = FETCH;
      FETCH: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = DECODE;
        end else if (timed_out) begin
          state_nxt = ERROR;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b10;
        case (OPCODE)
          3'b000:         state_nxt = EXEC_R;
          3'b011, 3'b101: state_nxt = MEM_ADDR;
          3'b110:         state_nxt = BRANCH;
          3'b111:         state_nxt = JUMP;
          default:        state_nxt = EXEC_I;
        endcase
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        if (funct_ok) begin
          state_nxt = WB_R;
        end else begin
          Illegal   = 1'b1;
          state_nxt = FETCH;
        end
      end
      WB_R: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        state_nxt = FETCH;
      end
      EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b11;
        state_nxt = WB_I;
      end
      WB_I: begin
        RegWrite  = 1'b1;
        state_nxt = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = (OPCODE == 3'b011) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          state_nxt = MEM_WB;
        end else if (timed_out) begin
          state_nxt = ERROR;
        end
      end
      MEM_WB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        state_nxt = FETCH;
      end
      MEM_WRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_nxt = FETCH;
        end else if (timed_out) begin
          state_nxt = ERROR;
        end
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_nxt   = FETCH;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        state_nxt = FETCH;
      end
      ERROR: begin
        Error     = 1'b1;
        state_nxt = ERROR;
      end
      default: state_nxt = RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: expected per-cycle control vectors are queued
// as stimulus is planned, then popped and compared at each falling edge.
module tb_multicycle_main_control;

  logic        Clock, Reset, MemReady;
  logic [15:0] InstrIn;
  logic        MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic        ALUSrcA, RegWrite, RegDst, MemToReg, Illegal, Error;
  logic [2:0]  OPCODE;
  logic [3:0]  Funct;

  multicycle_main_control #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .InstrIn(InstrIn), .MemReady(MemReady),
    .MemReq(MemReq), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .OPCODE(OPCODE), .Funct(Funct), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .Illegal(Illegal), .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       memreq, memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite, regdst, memtoreg, illegal, error;
  } ctl_t;

  typedef struct packed {
    logic [15:0] ins;
    logic        rdy;
    logic [3:0]  st;
    logic        chk_of;
    logic [2:0]  op;
    logic [3:0]  fn;
  } ent_t;

  localparam logic [3:0] T_RST = 4'd0, T_FETCH = 4'd1, T_DEC = 4'd2, T_EXR = 4'd3,
                         T_EXR_ILL = 4'd4, T_WBR = 4'd5, T_EXI = 4'd6, T_WBI = 4'd7,
                         T_MA = 4'd8, T_MR = 4'd9, T_MWB = 4'd10, T_MW = 4'd11,
                         T_BR = 4'd12, T_J = 4'd13, T_ERR = 4'd14;

  ctl_t  act;
  ent_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  string tname  = "";

  assign act = {MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemToReg,
                Illegal, Error};

  function automatic ctl_t exp_ctl(input logic [3:0] t, input logic rdy);
    ctl_t c;
    c = '0;
    case (t)
      T_FETCH: begin
        c.memreq = 1'b1; c.memread = 1'b1; c.alusrcb = 2'b01;
        c.irwrite = rdy; c.pcwrite = rdy;
      end
      T_DEC:     c.alusrcb = 2'b10;
      T_EXR:     begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      T_EXR_ILL: begin c.alusrca = 1'b1; c.aluop = 2'b10; c.illegal = 1'b1; end
      T_WBR:     begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      T_EXI:     begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; end
      T_WBI:     c.regwrite = 1'b1;
      T_MA:      begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      T_MR:      begin c.memreq = 1'b1; c.memread = 1'b1; c.iord = 1'b1; end
      T_MWB:     begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      T_MW:      begin c.memreq = 1'b1; c.memwrite = 1'b1; c.iord = 1'b1; end
      T_BR: begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
      end
      T_J:       begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      T_ERR:     c.error = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input logic [15:0] ins, input logic rdy, input logic [3:0] st,
                      input logic chk);
    ent_t e;
    e.ins = ins; e.rdy = rdy; e.st = st; e.chk_of = chk;
    e.op = ins[15:13]; e.fn = ins[3:0];
    sbq.push_back(e);
  endtask

  // Full instruction with MemReady tied high; sequence comes from the opcode map.
  task automatic push_instr(input logic [15:0] ins);
    logic [2:0] op;
    logic [3:0] fn;
    op = ins[15:13];
    fn = ins[3:0];
    push(ins, 1'b1, T_FETCH, 1'b0);
    push(ins, 1'b1, T_DEC, 1'b1);
    case (op)
      3'b000: begin
        if (fn == 4'b0000 || fn == 4'b0001 || fn == 4'b0010 || fn == 4'b1101) begin
          push(ins, 1'b1, T_EXR, 1'b1);
          push(ins, 1'b1, T_WBR, 1'b1);
        end else begin
          push(ins, 1'b1, T_EXR_ILL, 1'b1);
        end
      end
      3'b011: begin
        push(ins, 1'b1, T_MA, 1'b1); push(ins, 1'b1, T_MR, 1'b1); push(ins, 1'b1, T_MWB, 1'b1);
      end
      3'b101: begin push(ins, 1'b1, T_MA, 1'b1); push(ins, 1'b1, T_MW, 1'b1); end
      3'b110: push(ins, 1'b1, T_BR, 1'b1);
      3'b111: push(ins, 1'b1, T_J, 1'b1);
      default: begin push(ins, 1'b1, T_EXI, 1'b1); push(ins, 1'b1, T_WBI, 1'b1); end
    endcase
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic drain();
    ent_t e;
    ctl_t exp;
    while (sbq.size() > 0) begin
      InstrIn  = sbq[0].ins;
      MemReady = sbq[0].rdy;
      @(negedge Clock);
      e   = sbq.pop_front();
      exp = exp_ctl(e.st, e.rdy);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s ctl (step code %0d): got %h want %h", tname, e.st, act, exp);
      end
      if (e.chk_of) begin
        checks++;
        if ({OPCODE, Funct} !== {e.op, e.fn}) begin
          errors++;
          $display("FAIL %s opcode/funct: got %b/%b want %b/%b", tname, OPCODE, Funct, e.op, e.fn);
        end
      end
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check_all_zero(input string what);
    checks++;
    if (act !== '0 || OPCODE !== 3'b000 || Funct !== 4'b0000) begin
      errors++;
      $display("FAIL %s: ctl %h op %b fn %b, want all zero", what, act, OPCODE, Funct);
    end
  endtask

  task automatic test_reset();
    tname = "reset";
    Reset = 1'b0; MemReady = 1'b0; InstrIn = 16'h0000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_all_zero("reset_hold");
    @(posedge Clock); #1;
    Reset = 1'b1;
    push(16'h0000, 1'b0, T_RST, 1'b1);
    push(16'h0000, 1'b0, T_FETCH, 1'b0);
    push(16'h0000, 1'b0, T_FETCH, 1'b0);
    drain();
    #3;
    Reset = 1'b0;
    #1;
    check_all_zero("reset_mid_fetch");
    @(posedge Clock); #1;
    Reset = 1'b1;
    push(16'h0000, 1'b0, T_RST, 1'b1);
    push(16'h0000, 1'b0, T_FETCH, 1'b0);
    drain();
  endtask

  task automatic test_add();
    tname = "add";
    push_instr(16'h1230);
    drain();
  endtask

  task automatic test_ori_bne();
    tname = "ori_bne";
    push_instr(16'h4005);
    push_instr(16'hC005);
    drain();
  endtask

  task automatic test_lw_wait();
    tname = "lw_wait";
    push(16'h6004, 1'b1, T_FETCH, 1'b0);
    push(16'h6004, 1'b0, T_DEC, 1'b1);
    push(16'h6004, 1'b0, T_MA, 1'b1);
    for (int i = 0; i < 3; i++) push(16'h6004, 1'b0, T_MR, 1'b1);
    push(16'h6004, 1'b1, T_MR, 1'b1);
    push(16'h6004, 1'b0, T_MWB, 1'b1);
    drain();
  endtask

  task automatic test_illegal();
    tname = "illegal";
    push_instr(16'h0007);
    push_instr(16'h2001);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [8];
    tname = "back_to_back";
    prog = '{16'h0001, 16'h0002, 16'h000D, 16'h8003, 16'hA003, 16'hE000, 16'h6001, 16'h0009};
    foreach (prog[i]) push_instr(prog[i]);
    drain();
  endtask

  task automatic test_timeout_boundary();
    tname = "timeout_boundary";
    for (int i = 0; i < 15; i++) push(16'h000D, 1'b0, T_FETCH, 1'b0);
    push(16'h000D, 1'b1, T_FETCH, 1'b0);
    push(16'h000D, 1'b0, T_DEC, 1'b1);
    push(16'h000D, 1'b0, T_EXR, 1'b1);
    push(16'h000D, 1'b0, T_WBR, 1'b1);
    drain();
  endtask

  task automatic test_error();
    tname = "error";
    for (int i = 0; i < 16; i++) push(16'h4005, 1'b0, T_FETCH, 1'b0);
    for (int i = 0; i < 3; i++) push(16'h4005, 1'b1, T_ERR, 1'b0);
    drain();
    Reset = 1'b0;
    #1;
    check_all_zero("error_reset");
    @(posedge Clock); #1;
    Reset = 1'b1;
    push(16'h0000, 1'b0, T_RST, 1'b1);
    push(16'h0000, 1'b0, T_FETCH, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ori_bne();
    test_lw_wait();
    test_illegal();
    test_back_to_back();
    test_timeout_boundary();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
